// File: rtl/key_expansion.sv
// Iterative AES-128 key schedule.
// A start loads the cipher key into slot 0 and clears slots 1..10. Each of the
// next ten clocks then derives one round key from the previous one, so finish
// rises ten cycles after the start edge. All 11 round keys are presented on one
// flat bus, with round r at [128*r +: 128].
module key_expansion #(
    parameter int NR = 10,
    parameter int KW = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [KW-1:0]        key,
    input  logic                 start,
    output logic [KW*(NR+1)-1:0] expanded_key,
    output logic                 busy,
    output logic                 finish
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    // AES forward S-box. Byte 0x00 is the most significant byte of the table.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    state_t                  state_r;
    state_t                  next_state_s;
    logic [3:0]              round_r;
    logic [KW*(NR+1)-1:0]    expanded_key_r;
    logic [KW-1:0]           last_key_r;
    logic [KW-1:0]           next_key_s;
    logic                    busy_r;
    logic                    finish_r;
    logic                    load_s;
    logic                    step_s;
    logic                    last_s;

    // Byte substitution through the table; byte b sits at bit offset 8*(255-b).
    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        logic [10:0] idx;
        idx = {~b, 3'b000};
        return SBOX_TABLE[idx +: 8];
    endfunction

    // Apply the S-box to all four bytes of a word.
    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sub_byte(w[31:24]), sub_byte(w[23:16]),
                sub_byte(w[15:8]),  sub_byte(w[7:0])};
    endfunction

    // Round constant for rounds 1..10; unused round numbers map to zero.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] rc;
        case (r)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // One key-schedule round: {w0..w3} -> {n0..n3} using the shared S-box path.
    function automatic logic [127:0] round_fn(input logic [127:0] prev,
                                              input logic [7:0]   rc);
        logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
        w0 = prev[127:96];
        w1 = prev[95:64];
        w2 = prev[63:32];
        w3 = prev[31:0];
        t  = sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h000000};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // The previous round key is kept in its own register so the datapath
    // needs no wide read mux over the eleven slots.
    always_comb begin
        next_key_s = round_fn(last_key_r, rcon(round_r));
    end

    // State register; reset returns to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode and datapath strobes; start is ignored while expanding.
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        step_s       = 1'b0;
        last_s       = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    load_s       = 1'b1;
                    next_state_s = EXPAND;
                end else begin
                    next_state_s = state_r;
                end
            end
            EXPAND: begin
                step_s = 1'b1;
                if (round_r == NR[3:0]) begin
                    last_s       = 1'b1;
                    next_state_s = DONE;
                end else begin
                    next_state_s = EXPAND;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Key slots, round counter and handshake flags. Clearing every slot on
    // reset and on load keeps stale or partial schedules off the bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            expanded_key_r <= {(KW*(NR+1)){1'b0}};
            last_key_r     <= {KW{1'b0}};
            round_r        <= 4'd0;
            busy_r         <= 1'b0;
            finish_r       <= 1'b0;
        end else if (load_s) begin
            expanded_key_r <= {{(KW*NR){1'b0}}, key};
            last_key_r     <= key;
            round_r        <= 4'd1;
            busy_r         <= 1'b1;
            finish_r       <= 1'b0;
        end else if (step_s) begin
            expanded_key_r[{round_r, 7'b0000000} +: KW] <= next_key_s;
            last_key_r <= next_key_s;
            round_r    <= round_r + 4'd1;
            if (last_s) begin
                busy_r   <= 1'b0;
                finish_r <= 1'b1;
            end else begin
                busy_r   <= 1'b1;
                finish_r <= 1'b0;
            end
        end else begin
            expanded_key_r <= expanded_key_r;
            last_key_r     <= last_key_r;
            round_r        <= round_r;
            busy_r         <= busy_r;
            finish_r       <= finish_r;
        end
    end

    assign expanded_key = expanded_key_r;
    assign busy         = busy_r;
    assign finish       = finish_r;

endmodule

// File: tb/tb_key_expansion.sv
// Bench for key_expansion: directed FIPS-197 style vectors. Each expected
// schedule is queued when a start is issued; a monitor pops and compares it
// whenever finish rises.
module tb_key_expansion;

    logic          clk;
    logic          rst;
    logic [127:0]  key;
    logic          start;
    logic [1407:0] expanded_key;
    logic          busy;
    logic          finish;

    typedef struct {
        logic [127:0] k;
        logic [127:0] s1;
        logic [127:0] s10;
        int           start_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic finish_prev = 1'b0;

    localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A1_S1    = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A1_S10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_ZERO = 128'h0;
    localparam logic [127:0] Z_S1     = 128'h62636363626363636263636362636363;
    localparam logic [127:0] Z_S10    = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    key_expansion #(.NR(10), .KW(128)) dut (
        .clk          (clk),
        .rst          (rst),
        .key          (key),
        .start        (start),
        .expanded_key (expanded_key),
        .busy         (busy),
        .finish       (finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to measure start-to-finish latency.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] slot(input int r);
        return expanded_key[128*r +: 128];
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int r = 0; r <= 10; r++) check($sformatf("%s_slot%0d", tag, r), slot(r), 128'h0);
        check({tag, "_busy"},   {127'h0, busy},   128'h0);
        check({tag, "_finish"}, {127'h0, finish}, 128'h0);
    endtask

    // Monitor: on every rising finish, pop the oldest expectation and compare.
    always @(negedge clk) begin
        if (finish && !finish_prev) begin
            if (sb.size() == 0) begin
                check("unexpected_finish", 128'h1, 128'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("mon_slot0",   slot(0), e.k);
                check("mon_slot1",   slot(1), e.s1);
                check("mon_slot10",  slot(10), e.s10);
                check("mon_latency", 128'(cyc - e.start_cyc), 128'd10);
                check("mon_busy_low", {127'h0, busy}, 128'h0);
            end
        end
        finish_prev <= finish;
    end

    // Pulse start for one edge; returns at the negedge after that edge (E0).
    task automatic run_start(input logic [127:0] k, input logic [127:0] s1,
                             input logic [127:0] s10, input bit expect_done);
        exp_t e;
        @(negedge clk);
        key   = k;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (expect_done) begin
            e.k = k; e.s1 = s1; e.s10 = s10; e.start_cyc = cyc;
            sb.push_back(e);
        end
        check("e0_busy",   {127'h0, busy},   128'h1);
        check("e0_finish", {127'h0, finish}, 128'h0);
        check("e0_slot0",  slot(0), k);
        for (int r = 1; r <= 10; r++) check($sformatf("e0_slot%0d_clear", r), slot(r), 128'h0);
    endtask

    task automatic wait_finish();
        int n = 0;
        while (!finish && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("finish_timeout", {127'h0, finish}, 128'h1);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        key   = 128'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_all_zero("reset");
        repeat (5) @(negedge clk);
        check_all_zero("idle_hold");

        // FIPS-197 A.1 with per-cycle busy tracking.
        run_start(KEY_A1, A1_S1, A1_S10, 1'b1);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            check($sformatf("a1_busy_e%0d", i), {126'h0, busy, finish}, 128'h2);
        end
        @(negedge clk);
        check("a1_e10_flags", {126'h0, busy, finish}, 128'h1);
        repeat (4) @(negedge clk);
        check("a1_done_hold_finish", {127'h0, finish}, 128'h1);
        check("a1_done_hold_slot10", slot(10), A1_S10);

        // Start re-pulsed mid-run with a different key must be ignored.
        run_start(KEY_A1, A1_S1, A1_S10, 1'b1);
        repeat (3) @(negedge clk);
        key   = 128'hdeadbeef00112233445566778899aabb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_finish();
        check("repulse_slot0", slot(0), KEY_A1);

        // Reset mid-expansion clears everything; no finish may follow.
        run_start(KEY_ZERO, Z_S1, Z_S10, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("abort");
        repeat (3) @(negedge clk);
        check_all_zero("abort_idle");

        // Fresh run after the abort completes normally.
        run_start(KEY_A1, A1_S1, A1_S10, 1'b1);
        wait_finish();

        // Restart from DONE with the zero key.
        run_start(KEY_ZERO, Z_S1, Z_S10, 1'b1);
        repeat (4) @(negedge clk);
        check("restart_slot10_unwritten", slot(10), 128'h0);
        check("restart_slot1", slot(1), Z_S1);
        wait_finish();
        check("restart_slot10", slot(10), Z_S10);

        repeat (3) @(negedge clk);
        check("queue_drained", 128'(sb.size()), 128'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
